arbiter_weighted: RTL and testbench
===================================

Name: arbiter_weighted

Overview:
- Parametrised successor to the team's simple round-robin timeout arbiter.
- Grants one of NUM_PORTS requesters at a time, with a per-port programmable grant quantum (weight) instead of a single global TIMEOUT.
- Selectable round-robin or fixed-priority mode, plus an encoded grant index for mux steering.
- Sits in front of shared resources such as memory ports or bus masters.

Parameters:
- NUM_PORTS, 4, number of requesters (>=2).
- WEIGHT_W, 4, bit width of each per-port weight and of the quantum counter.
- MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- IDX_W, $clog2(NUM_PORTS), width of grant_idx.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- request  in  NUM_PORTS  per-port request, level sensitive.
- weight  in  NUM_PORTS*WEIGHT_W  per-port quantum; port i uses bits [i*WEIGHT_W +: WEIGHT_W].
- grant  out  NUM_PORTS  one-hot registered grant, all-zero when idle.
- grant_idx  out  IDX_W  binary index of the granted port; holds its last value when idle.
- active  out  1  high when any grant bit is set.
- quantum_end  out  1  one-cycle pulse on the last cycle of an owner's quantum.

Behaviour:
- Reset (rst_n low, asynchronous): grant=0, grant_idx=0, active=0, quantum_end=0, counter=0, state=IDLE. The RR pointer is set so that port 0 has the highest priority.
- Release: outputs are updated on the first clk rising edge after rst_n rises.
- States: IDLE and OWNED. All outputs are registered.
- IDLE:
  - If request is nonzero at edge n, the winner is granted at edge n (grant visible in cycle n+1).
  - Latency from request to grant is 1 cycle.
- Winner selection:
  - MODE 0: first requesting port scanning upward from (last_owner+1) mod NUM_PORTS.
  - MODE 1: lowest-index requesting port.
- Grant load: counter = weight[winner]. A weight of 0 is treated as 1. The weight is sampled only at grant time; changes mid-quantum are ignored.
- OWNED, on each edge:
  - Owner request low: release. If other requests are pending, grant the next winner on the same edge (zero-gap handover); otherwise go to IDLE with grant=0.
  - Owner still requesting and counter>1: decrement counter and keep the grant.
  - Owner still requesting and counter==1 (quantum exhausted):
    - quantum_end is high during this cycle.
    - At the edge, re-arbitrate with the owner excluded. If another port wins, hand over the grant.
    - If no other port is requesting, or MODE 1 selects the owner again, the owner is re-granted with a fresh counter and grant stays continuously high.
- RR pointer: updates to the new owner on every grant load. In MODE 1 the pointer is unused.
- Grant is always one-hot or zero; no two bits are ever set.
- The counter is WEIGHT_W bits, so the maximum quantum is 2^WEIGHT_W-1 cycles.
- Requests that appear during a quantum do not pre-empt the owner in either mode.
- Reset asserted mid-quantum: grant drops immediately (asynchronous), and the pointer returns to its reset value.

Test Plan:
- Weighted RR: NUM_PORTS=3, weights {p0=3, p1=2, p2=1}, request=111 held.
  - Required grant sequence: 001 x3, 010 x2, 100 x1, repeating.
  - quantum_end pulses on the 3rd, 5th and 6th cycles.
  - active is constant 1 throughout.
- Sole requester: request=010, weight p1=2.
  - grant=010 from 1 cycle after request and stays continuously high.
  - quantum_end pulses every 2 cycles; grant_idx=1.
- Early drop:
  - request=011, p0 weight=5; drop p0 after 2 grant cycles.
    - Required: grant goes 001 -> 010 on the same edge, no idle cycle.
  - Then request=000.
    - Required: grant=000 and active=0 one cycle later; grant_idx holds 1.
- Zero weight: all weights=0, request=111.
  - Required: grant rotates 001, 010, 100 every cycle; quantum_end high every cycle.
- MODE=1: weights all 2, request=110 then 111.
  - Required: p1 is held (re-granted) while it keeps requesting; p0 wins at the first quantum expiry after its request rises.
  - Required: p2 is never granted while p0 or p1 request.
- Async reset mid-quantum: assert rst_n=0 between clock edges while grant=010.
  - Required: grant=000, active=0 before the next edge.
  - Required: after release with request=111, the first grant is 001.

Source files
------------

// File: rtl/arbiter_weighted.sv
// Weighted arbiter: grants one requester at a time for a per-port quantum (weight),
// in round-robin or fixed-priority order. Exposes an encoded grant index and an end-of-quantum pulse.
module arbiter_weighted #(
  parameter int NUM_PORTS = 4,
  parameter int WEIGHT_W  = 4,
  parameter int MODE      = 0,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          request,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          active,
  output logic                          quantum_end
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_reg;
  logic [NUM_PORTS-1:0]   grant_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic [IDX_W-1:0]       ptr_reg;
  logic [WEIGHT_W-1:0]    count_reg;
  logic                   active_reg;
  logic                   qe_reg;

  logic [WEIGHT_W-1:0]    weight_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0]   hi_mask;
  logic [NUM_PORTS-1:0]   cand;
  logic [NUM_PORTS-1:0]   cand_hi;
  logic [NUM_PORTS-1:0]   load_onehot;
  logic                   owner_req;
  logic                   exhausted;
  logic                   win_valid;
  logic [IDX_W-1:0]       win_idx;
  logic                   load_en;
  logic [IDX_W-1:0]       load_idx;
  logic [WEIGHT_W-1:0]    load_raw;
  logic [WEIGHT_W-1:0]    load_count;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_PORTS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // hi_mask marks ports strictly above the last owner; empty in fixed-priority mode
  // so the scan degenerates to lowest-index-wins.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign weight_arr[gi]  = weight[gi*WEIGHT_W +: WEIGHT_W];
      assign hi_mask[gi]     = (MODE == 0) && (IDX_W'(gi) > ptr_reg);
      assign load_onehot[gi] = (load_idx == IDX_W'(gi));
    end
  endgenerate

  // Round-robin excludes the current owner from re-arbitration; fixed priority keeps it
  // so a higher-priority owner can be re-granted at quantum expiry.
  assign cand      = (MODE == 1) ? request : (request & ~grant_reg);
  assign cand_hi   = cand & hi_mask;
  assign win_valid = |cand;
  assign win_idx   = (|cand_hi) ? lowest_set(cand_hi) : lowest_set(cand);

  assign owner_req = |(request & grant_reg);
  assign exhausted = (count_reg == WEIGHT_W'(1));

  always_comb begin
    load_en = 1'b0;
    unique case (state_reg)
      IDLE:    load_en = win_valid;
      OWNED:   load_en = (!owner_req && win_valid) || (owner_req && exhausted);
      default: load_en = 1'b0;
    endcase
  end

  // With no other contender at expiry, the owner reloads its own quantum.
  assign load_idx   = win_valid ? win_idx : idx_reg;
  assign load_raw   = weight_arr[load_idx];
  assign load_count = (load_raw == '0) ? WEIGHT_W'(1) : load_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      idx_reg    <= '0;
      ptr_reg    <= IDX_W'(NUM_PORTS - 1);
      count_reg  <= '0;
      active_reg <= 1'b0;
      qe_reg     <= 1'b0;
    end else if (load_en) begin
      state_reg  <= OWNED;
      grant_reg  <= load_onehot;
      idx_reg    <= load_idx;
      ptr_reg    <= load_idx;
      count_reg  <= load_count;
      active_reg <= 1'b1;
      qe_reg     <= (load_count == WEIGHT_W'(1));
    end else begin
      unique case (state_reg)
        OWNED: begin
          if (owner_req) begin
            count_reg <= count_reg - WEIGHT_W'(1);
            qe_reg    <= (count_reg == WEIGHT_W'(2));
          end else begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            count_reg  <= '0;
            active_reg <= 1'b0;
            qe_reg     <= 1'b0;
          end
        end
        default: begin
          state_reg  <= IDLE;
          grant_reg  <= '0;
          count_reg  <= '0;
          active_reg <= 1'b0;
          qe_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = grant_reg;
  assign grant_idx   = idx_reg;
  assign active      = active_reg;
  assign quantum_end = qe_reg;

endmodule

// File: tb/tb_arbiter_weighted.sv
// Directed bench for arbiter_weighted: a round-robin instance driven from a vector table,
// plus hand sequences for asynchronous reset and a fixed-priority instance.
module tb_arbiter_weighted;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_rr, req_fp;
  logic [11:0] w_rr, w_fp;
  logic [2:0]  g_rr, g_fp;
  logic [1:0]  idx_rr, idx_fp;
  logic        act_rr, act_fp, qe_rr, qe_fp;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  req;
    logic [11:0] w;
    logic [2:0]  g;
    logic [1:0]  idx;
    logic        act;
    logic        qe;
  } vector_t;

  vector_t vecs[$];

  always #5 clk = ~clk;

  arbiter_weighted #(.NUM_PORTS(3), .WEIGHT_W(4), .MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .request(req_rr), .weight(w_rr),
    .grant(g_rr), .grant_idx(idx_rr), .active(act_rr), .quantum_end(qe_rr)
  );

  arbiter_weighted #(.NUM_PORTS(3), .WEIGHT_W(4), .MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .request(req_fp), .weight(w_fp),
    .grant(g_fp), .grant_idx(idx_fp), .active(act_fp), .quantum_end(qe_fp)
  );

  task automatic add(input logic [2:0] r, input logic [11:0] w, input logic [2:0] g,
                     input logic [1:0] i, input logic a, input logic q);
    vector_t v;
    v.req = r; v.w = w; v.g = g; v.idx = i; v.act = a; v.qe = q;
    vecs.push_back(v);
  endtask

  task automatic check(input string name,
                       input logic [2:0] ag, input logic [1:0] ai, input logic aa, input logic aq,
                       input logic [2:0] eg, input logic [1:0] ei, input logic ea, input logic eq);
    n_vec++;
    if (ag !== eg || ai !== ei || aa !== ea || aq !== eq || !$onehot0(ag)) begin
      n_err++;
      $display("FAIL %s: got grant=%b idx=%0d active=%b qe=%b, expected grant=%b idx=%0d active=%b qe=%b",
               name, ag, ai, aa, aq, eg, ei, ea, eq);
    end else begin
      $display("ok   %s: grant=%b idx=%0d active=%b qe=%b", name, ag, ai, aa, aq);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // weighted RR, weights p0=3 p1=2 p2=1, all requesting
    for (int rep = 0; rep < 2; rep++) begin
      add(3'b111, 12'h123, 3'b001, 2'd0, 1'b1, 1'b0);
      add(3'b111, 12'h123, 3'b001, 2'd0, 1'b1, 1'b0);
      add(3'b111, 12'h123, 3'b001, 2'd0, 1'b1, 1'b1);
      add(3'b111, 12'h123, 3'b010, 2'd1, 1'b1, 1'b0);
      add(3'b111, 12'h123, 3'b010, 2'd1, 1'b1, 1'b1);
      add(3'b111, 12'h123, 3'b100, 2'd2, 1'b1, 1'b1);
    end
    add(3'b000, 12'h123, 3'b000, 2'd2, 1'b0, 1'b0);
    // sole requester p1, weight 2
    add(3'b010, 12'h123, 3'b010, 2'd1, 1'b1, 1'b0);
    add(3'b010, 12'h123, 3'b010, 2'd1, 1'b1, 1'b1);
    add(3'b010, 12'h123, 3'b010, 2'd1, 1'b1, 1'b0);
    add(3'b010, 12'h123, 3'b010, 2'd1, 1'b1, 1'b1);
    add(3'b010, 12'h123, 3'b010, 2'd1, 1'b1, 1'b0);
    add(3'b000, 12'h123, 3'b000, 2'd1, 1'b0, 1'b0);
    // early drop: p0 weight 5 released after two cycles, zero-gap handover to p1
    add(3'b011, 12'h125, 3'b001, 2'd0, 1'b1, 1'b0);
    add(3'b011, 12'h125, 3'b001, 2'd0, 1'b1, 1'b0);
    add(3'b010, 12'h125, 3'b010, 2'd1, 1'b1, 1'b0);
    add(3'b000, 12'h125, 3'b000, 2'd1, 1'b0, 1'b0);
    // zero weights behave as one-cycle quanta
    add(3'b111, 12'h000, 3'b100, 2'd2, 1'b1, 1'b1);
    add(3'b111, 12'h000, 3'b001, 2'd0, 1'b1, 1'b1);
    add(3'b111, 12'h000, 3'b010, 2'd1, 1'b1, 1'b1);
    add(3'b111, 12'h000, 3'b100, 2'd2, 1'b1, 1'b1);

    rst_n = 1'b0; req_rr = '0; req_fp = '0; w_rr = '0; w_fp = 12'h222;
    #12;
    check("reset_rr", g_rr, idx_rr, act_rr, qe_rr, 3'b000, 2'd0, 1'b0, 1'b0);
    check("reset_fp", g_fp, idx_fp, act_fp, qe_fp, 3'b000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      req_rr = vecs[i].req;
      w_rr   = vecs[i].w;
      tick();
      check($sformatf("vec%0d", i), g_rr, idx_rr, act_rr, qe_rr,
            vecs[i].g, vecs[i].idx, vecs[i].act, vecs[i].qe);
    end

    // async reset while p1 owns the grant
    req_rr = 3'b111; w_rr = 12'h222;
    tick(); check("pre_rst_a", g_rr, idx_rr, act_rr, qe_rr, 3'b001, 2'd0, 1'b1, 1'b0);
    tick(); check("pre_rst_b", g_rr, idx_rr, act_rr, qe_rr, 3'b001, 2'd0, 1'b1, 1'b1);
    tick(); check("pre_rst_c", g_rr, idx_rr, act_rr, qe_rr, 3'b010, 2'd1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("async_rst", g_rr, idx_rr, act_rr, qe_rr, 3'b000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; w_rr = 12'h123;
    tick(); check("post_rst", g_rr, idx_rr, act_rr, qe_rr, 3'b001, 2'd0, 1'b1, 1'b0);

    // fixed priority: p1 keeps re-winning until p0 rises, p2 never wins
    req_fp = 3'b110;
    tick(); check("fp_a", g_fp, idx_fp, act_fp, qe_fp, 3'b010, 2'd1, 1'b1, 1'b0);
    tick(); check("fp_b", g_fp, idx_fp, act_fp, qe_fp, 3'b010, 2'd1, 1'b1, 1'b1);
    tick(); check("fp_c", g_fp, idx_fp, act_fp, qe_fp, 3'b010, 2'd1, 1'b1, 1'b0);
    req_fp = 3'b111;
    tick(); check("fp_d", g_fp, idx_fp, act_fp, qe_fp, 3'b010, 2'd1, 1'b1, 1'b1);
    tick(); check("fp_e", g_fp, idx_fp, act_fp, qe_fp, 3'b001, 2'd0, 1'b1, 1'b0);
    tick(); check("fp_f", g_fp, idx_fp, act_fp, qe_fp, 3'b001, 2'd0, 1'b1, 1'b1);
    tick(); check("fp_g", g_fp, idx_fp, act_fp, qe_fp, 3'b001, 2'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
